// File: rtl/output_uart_tx.sv
// Serial 8N1 transmitter for values latched into the output register.
// Each accepted write is queued in a small FIFO and sent as a UART frame on tx.
module output_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load,
    input  logic [DATA_WIDTH-1:0]         data_in,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          fifo_full,
    output logic                          overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BIT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] COUNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] COUNT_ZERO = CNT_W'(0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                  state_r;
    logic [BIT_W-1:0]        bit_cnt_r;
    logic [IDX_W-1:0]        bit_idx_r;
    logic [DATA_WIDTH-1:0]   shift_r;
    logic [DATA_WIDTH-1:0]   mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_r;
    logic [PTR_W-1:0]        rd_ptr_r;

    logic                    bit_end_s;
    logic                    stop_end_s;
    logic                    pop_s;
    logic                    wr_s;
    logic                    next_idle_s;
    logic [CNT_W-1:0]        count_next_s;
    logic [DATA_WIDTH-1:0]   head_s;
    logic [IDX_W-1:0]        idx_next_s;

    // Pop/write decisions and next-cycle FIFO occupancy.
    always_comb begin
        bit_end_s  = (bit_cnt_r == BIT_LAST);
        stop_end_s = (state_r == STOP) && bit_end_s;
        idx_next_s = bit_idx_r + IDX_W'(1);

        case (state_r)
            IDLE:    pop_s = (fifo_count != COUNT_ZERO);
            // A load on the STOP-end edge counts as queued, so frames chain without a gap.
            STOP:    pop_s = bit_end_s && ((fifo_count != COUNT_ZERO) || load);
            default: pop_s = 1'b0;
        endcase

        wr_s = load && (!fifo_full || pop_s);

        if (fifo_count != COUNT_ZERO) begin
            head_s = mem_r[rd_ptr_r];
        end else begin
            head_s = data_in;
        end

        count_next_s = fifo_count + CNT_W'(wr_s) - CNT_W'(pop_s);
        next_idle_s  = ((state_r == IDLE) && !pop_s) || (stop_end_s && !pop_s);
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_r[wr_ptr_r] <= data_in;
        end
    end

    // FIFO pointers, occupancy and status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            fifo_count <= '0;
            fifo_full  <= 1'b0;
            busy       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (wr_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            if (load && !wr_s) begin
                overflow <= 1'b1;
            end
            fifo_count <= count_next_s;
            fifo_full  <= (count_next_s == COUNT_FULL);
            busy       <= !next_idle_s || (count_next_s != COUNT_ZERO);
        end
    end

    // Frame sequencer; tx is updated together with the state so it never glitches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            bit_cnt_r <= '0;
            bit_idx_r <= '0;
            shift_r   <= '0;
            tx        <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    bit_cnt_r <= '0;
                    if (pop_s) begin
                        shift_r <= head_s;
                        state_r <= START;
                        tx      <= 1'b0;
                    end else begin
                        tx      <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end_s) begin
                        bit_cnt_r <= '0;
                        bit_idx_r <= '0;
                        state_r   <= DATA;
                        tx        <= shift_r[0];
                    end else begin
                        bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end_s) begin
                        bit_cnt_r <= '0;
                        if (bit_idx_r == IDX_LAST) begin
                            state_r <= STOP;
                            tx      <= 1'b1;
                        end else begin
                            bit_idx_r <= idx_next_s;
                            tx        <= shift_r[idx_next_s];
                        end
                    end else begin
                        bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                    end
                end
                STOP: begin
                    if (bit_end_s) begin
                        bit_cnt_r <= '0;
                        if (pop_s) begin
                            shift_r <= head_s;
                            state_r <= START;
                            tx      <= 1'b0;
                        end else begin
                            state_r <= IDLE;
                            tx      <= 1'b1;
                        end
                    end else begin
                        bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    bit_cnt_r <= '0;
                    tx        <= 1'b1;
                end
            endcase
        end
    end

endmodule
